// File: rtl/seq_pkg.sv
// Shared definitions for the sequence-detector test path: FSM encoding, default
// target pattern (also used by the detector FSM) and the stimulus LFSR polynomial.
package seq_pkg;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_FILL   = 2'd1,
      S_INJECT = 2'd2,
      S_DONE   = 2'd3
   } seq_state_t;

   typedef struct packed {
      seq_state_t  state;
      logic [7:0]  cnt;
      logic [15:0] lfsr;
   } seq_dbg_t;

   localparam int                   DEF_PAT_W   = 4;
   localparam logic [DEF_PAT_W-1:0] DEF_PATTERN = 4'b1011;

   // x^16+x^14+x^13+x^11+1 as a right-shifting Fibonacci register: taps 0,2,3,5
   localparam logic [15:0] LFSR_TAPS = 16'h002D;

   function automatic logic [15:0] lfsr_advance(input logic [15:0] s);
      logic [15:0] n;
      n = {^(s & LFSR_TAPS), s[15:1]};
      return (n == 16'h0000) ? 16'h0001 : n;
   endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit filler LFSR. lfsr_bit is the bit that would be emitted this cycle,
// already reflecting a same-cycle load so the first fill bit needs no bubble.
module lfsr16
   import seq_pkg::*;
#(
   parameter logic [15:0] RST_SEED = 16'hACE1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        load,
   input  logic [15:0] seed,
   input  logic        step,
   output logic        lfsr_bit,
   output logic [15:0] lfsr_state
);

   logic [15:0] cur;

   // All-zero is a lock-up state; substitute 1 wherever it could appear
   always_comb begin
      cur = load ? seed : lfsr_state;
      if (cur == 16'h0000) cur = 16'h0001;
   end

   assign lfsr_bit = cur[0];

   always_ff @(posedge clk or posedge rst) begin
      if (rst)              lfsr_state <= RST_SEED;
      else if (step)        lfsr_state <= lfsr_advance(cur);
      else if (load)        lfsr_state <= cur;
   end

endmodule

// File: rtl/seq_injector.sv
// Serial stimulus transmitter: pseudorandom filler with a target pattern injected
// n_inj times per frame, plus the golden detect strobe for the downstream checker.
module seq_injector
   import seq_pkg::*;
#(
   parameter int               PAT_W   = DEF_PAT_W,
   parameter logic [PAT_W-1:0] PATTERN = PAT_W'(DEF_PATTERN),
   parameter logic [15:0]      SEED    = 16'hACE1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [7:0] gap_len,
   input  logic [7:0] n_inj,
   output logic       dout,
   output logic       dout_valid,
   output logic       exp_detect,
   output logic       busy,
   output logic       done,
   output logic [7:0] inj_count,
   output seq_dbg_t   dbg
);

   localparam int         IDX_W    = (PAT_W > 1) ? $clog2(PAT_W) : 1;
   localparam logic [7:0] LAST_PAT = 8'(PAT_W - 1);

   seq_state_t       state, next_state;
   logic [7:0]       cnt, cnt_n;
   logic [7:0]       gap_q, n_q;
   logic [PAT_W-2:0] hist;
   logic [PAT_W-1:0] win_n;
   logic [IDX_W-1:0] pat_idx;
   logic             start_ok, inj_last, lfsr_step, fill_bit;
   logic             dout_d, valid_d, busy_d, done_d;
   logic [15:0]      lfsr_state;

   lfsr16 #(.RST_SEED(SEED)) u_lfsr (
      .clk        (clk),
      .rst        (rst),
      .load       (start_ok),
      .seed       (SEED),
      .step       (lfsr_step),
      .lfsr_bit   (fill_bit),
      .lfsr_state (lfsr_state)
   );

   // State register: state names the phase of the bit currently on dout
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= next_state;
   end

   always_comb begin
      next_state = state;
      cnt_n      = cnt;
      unique case (state)
         S_IDLE: begin
            if (start) begin
               cnt_n = 8'd0;
               if (n_inj == 8'd0)        next_state = S_DONE;
               else if (gap_len == 8'd0) next_state = S_INJECT;
               else                      next_state = S_FILL;
            end
         end
         S_FILL: begin
            if (cnt == gap_q - 8'd1) begin
               next_state = S_INJECT;
               cnt_n      = 8'd0;
            end else begin
               cnt_n = cnt + 8'd1;
            end
         end
         S_INJECT: begin
            if (cnt == LAST_PAT) begin
               cnt_n = 8'd0;
               if (inj_count + 8'd1 == n_q) next_state = S_DONE;
               else if (gap_q == 8'd0)      next_state = S_INJECT;
               else                         next_state = S_FILL;
            end else begin
               cnt_n = cnt + 8'd1;
            end
         end
         S_DONE:  next_state = S_IDLE;
         default: next_state = S_IDLE;
      endcase
   end

   // Output decode: computes next-cycle values so every output leaves a flop.
   // dout carries a stream bit only when dout_valid is high; there is no backpressure.
   always_comb begin
      start_ok  = (state == S_IDLE) && start;
      inj_last  = (state == S_INJECT) && (cnt == LAST_PAT);
      lfsr_step = (next_state == S_FILL);
      pat_idx   = IDX_W'(LAST_PAT) - IDX_W'(cnt_n);
      valid_d   = (next_state == S_FILL) || (next_state == S_INJECT);
      busy_d    = valid_d || start_ok;
      done_d    = (next_state == S_DONE);
      dout_d    = 1'b0;
      if (next_state == S_FILL)        dout_d = fill_bit;
      else if (next_state == S_INJECT) dout_d = PATTERN[pat_idx];
      win_n     = {hist, dout};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt        <= 8'd0;
         gap_q      <= 8'd0;
         n_q        <= 8'd0;
         inj_count  <= 8'd0;
         hist       <= '0;
         dout       <= 1'b0;
         dout_valid <= 1'b0;
         exp_detect <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
      end else begin
         cnt        <= cnt_n;
         dout       <= dout_d;
         dout_valid <= valid_d;
         busy       <= busy_d;
         done       <= done_d;
         if (start_ok) begin
            gap_q      <= gap_len;
            n_q        <= n_inj;
            inj_count  <= 8'd0;
            hist       <= '0;
            exp_detect <= 1'b0;
         end else begin
            if (inj_last)   inj_count <= inj_count + 8'd1;
            if (dout_valid) hist      <= win_n[PAT_W-2:0];
            // One cycle behind the completing bit, like a Moore detector
            exp_detect <= dout_valid && (win_n == PATTERN);
         end
      end
   end

   assign dbg.state = state;
   assign dbg.cnt   = cnt;
   assign dbg.lfsr  = lfsr_state;

endmodule

// File: tb/tb_seq_injector.sv
// Directed bench for seq_injector: hand-computed streams, framing and reset
// behaviour, and a closed loop against a Moore 1011 detector.
module tb_seq_injector;
   import seq_pkg::*;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [7:0] gap_len;
   logic [7:0] n_inj;
   logic       dout, dout_valid, exp_detect, busy, done;
   logic [7:0] inj_count;
   seq_dbg_t   dbg;

   int checks = 0;
   int errors = 0;

   logic [0:0]  exp_q[$];
   int          f_cyc, f_val, f_det, f_busy, f_mism, f_first, f_done;
   logic [63:0] f_bits, f_det_mask;
   logic        f_busy_done;

   logic [2:0]  det_st;
   logic        detect;

   seq_injector dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .gap_len    (gap_len),
      .n_inj      (n_inj),
      .dout       (dout),
      .dout_valid (dout_valid),
      .exp_detect (exp_detect),
      .busy       (busy),
      .done       (done),
      .inj_count  (inj_count),
      .dbg        (dbg)
   );

   // clock / reset
   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

   // Moore detector for 1011 with overlap; drops to idle on any gap in the stream
   function automatic logic [2:0] det_next(input logic [2:0] s, input logic b);
      case (s)
         3'd0:    return b ? 3'd1 : 3'd0;
         3'd1:    return b ? 3'd1 : 3'd2;
         3'd2:    return b ? 3'd3 : 3'd0;
         3'd3:    return b ? 3'd4 : 3'd2;
         default: return b ? 3'd1 : 3'd2;
      endcase
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst)             det_st <= 3'd0;
      else if (!dout_valid) det_st <= 3'd0;
      else                 det_st <= det_next(det_st, dout);
   end
   assign detect = (det_st == 3'd4);

   function automatic logic [15:0] lfsr_ref(input logic [15:0] s);
      logic fb;
      fb = s[0] ^ s[2] ^ s[3] ^ s[5];
      return {fb, s[15:1]};
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // driver tasks
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic kick(input logic [7:0] g, input logic [7:0] n);
      gap_len = g;
      n_inj   = n;
      start   = 1'b1;
   endtask

   task automatic push_frame(input logic [7:0] g, input logic [7:0] n);
      logic [15:0] s;
      logic [3:0]  p;
      s = 16'hACE1;
      p = 4'b1011;
      for (int i = 0; i < int'(n); i++) begin
         for (int j = 0; j < int'(g); j++) begin
            exp_q.push_back(s[0]);
            s = lfsr_ref(s);
         end
         for (int k = 3; k >= 0; k--) exp_q.push_back(p[k]);
      end
   endtask

   task automatic clear_obs();
      f_val = 0; f_det = 0; f_busy = 0; f_mism = 0; f_first = -1; f_done = -1;
      f_bits = '0; f_det_mask = '0; f_busy_done = 1'b0;
   endtask

   // scoreboard: one cycle of observation
   task automatic observe();
      logic [0:0] b;
      if (dout_valid) begin
         f_val++;
         if (f_first < 0) f_first = f_cyc;
         f_bits = {f_bits[62:0], dout};
         if (exp_q.size() == 0) check("extra_bit", 32'd1, 32'd0);
         else begin
            b = exp_q.pop_front();
            check("dout_bit", 32'(dout), 32'(b));
         end
      end
      if (exp_detect) begin
         f_det++;
         if (f_cyc < 64) f_det_mask[f_cyc] = 1'b1;
      end
      if (busy) f_busy++;
      if (detect !== exp_detect) f_mism++;
   endtask

   task automatic capture(input int budget);
      clear_obs();
      for (int c = 1; c <= budget; c++) begin
         tick();
         f_cyc = c;
         if (c == 1) start = 1'b0;
         observe();
         if (done) begin
            f_done      = c;
            f_busy_done = busy;
            break;
         end
      end
      if (f_done < 0) check("done_timeout", 32'd0, 32'd1);
   endtask

   initial begin
      int d1, d2, seen_done;
      logic idle_busy, new_busy;
      logic [7:0] g, n;

      rst = 1'b1; start = 1'b0; gap_len = 8'd0; n_inj = 8'd0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_dout",    32'(dout), 32'd0);
      check("rst_valid",   32'(dout_valid), 32'd0);
      check("rst_exp_det", 32'(exp_detect), 32'd0);
      check("rst_busy",    32'(busy), 32'd0);
      check("rst_done",    32'(done), 32'd0);
      check("rst_inj_cnt", 32'(inj_count), 32'd0);
      check("rst_state",   32'(dbg.state), 32'(S_IDLE));
      check("rst_lfsr",    32'(dbg.lfsr), 32'h0000ACE1);
      rst = 1'b0;
      tick();

      // zero gap: 1011 x3
      push_frame(8'd0, 8'd3);
      kick(8'd0, 8'd3);
      capture(40);
      check("zg_valid",   32'(f_val), 32'd12);
      check("zg_first",   32'(f_first), 32'd1);
      check("zg_bits",    32'(f_bits), 32'h00000BBB);
      check("zg_det_pos", 32'(f_det_mask), 32'h00002220);
      check("zg_done_at", 32'(f_done), 32'd13);
      check("zg_busy",    32'(f_busy), 32'd12);
      check("zg_busy_dn", 32'(f_busy_done), 32'd0);
      check("zg_inj_cnt", 32'(inj_count), 32'd3);
      check("zg_q_left",  32'(exp_q.size()), 32'd0);
      tick(); tick(); tick();
      check("zg_cnt_hold", 32'(inj_count), 32'd3);

      // empty frame
      kick(8'd5, 8'd0);
      capture(10);
      check("ef_done_at", 32'(f_done), 32'd1);
      check("ef_valid",   32'(f_val), 32'd0);
      check("ef_busy",    32'(f_busy), 32'd1);
      check("ef_inj_cnt", 32'(inj_count), 32'd0);
      tick();
      check("ef_busy_off", 32'(busy), 32'd0);

      // gapped frame: fill 10000, 1011, fill 11100, 1011
      push_frame(8'd5, 8'd2);
      kick(8'd5, 8'd2);
      capture(60);
      check("gf_valid",   32'(f_val), 32'd18);
      check("gf_bits",    32'(f_bits), 32'h000217CB);
      check("gf_det",     32'(f_det), 32'd2);
      check("gf_det_pos", 32'(f_det_mask), 32'h00080400);
      check("gf_done_at", 32'(f_done), 32'd19);
      check("gf_inj_cnt", 32'(inj_count), 32'd2);
      check("gf_mism",    32'(f_mism), 32'd0);
      tick();

      // start ignored mid-frame and in DONE; held start launches next frame
      push_frame(8'd1, 8'd2);
      push_frame(8'd0, 8'd1);
      clear_obs();
      d1 = -1; d2 = -1; idle_busy = 1'b1; new_busy = 1'b0;
      kick(8'd1, 8'd2);
      for (int c = 1; c <= 60 && d2 < 0; c++) begin
         tick();
         f_cyc = c;
         if (c == 1) start = 1'b0;
         observe();
         if (c == 3) begin start = 1'b1; gap_len = 8'd7; n_inj = 8'd5; end
         if (c == 4) start = 1'b0;
         if (done && d1 < 0) begin
            d1 = c; start = 1'b1; gap_len = 8'd0; n_inj = 8'd1;
         end else if (done) d2 = c;
         if (d1 > 0 && c == d1 + 1) idle_busy = busy;
         if (d1 > 0 && c == d1 + 2) begin start = 1'b0; new_busy = busy; end
      end
      check("ig_done1",     32'(d1), 32'd11);
      check("ig_idle_busy", 32'(idle_busy), 32'd0);
      check("ig_new_busy",  32'(new_busy), 32'd1);
      check("ig_done2",     32'(d2), 32'd17);
      check("ig_valid",     32'(f_val), 32'd14);
      check("ig_inj_cnt",   32'(inj_count), 32'd1);
      check("ig_q_left",    32'(exp_q.size()), 32'd0);
      tick();

      // reset during INJECT
      push_frame(8'd5, 8'd2);
      clear_obs();
      seen_done = 0;
      kick(8'd5, 8'd2);
      for (int c = 1; c <= 7; c++) begin
         tick();
         f_cyc = c;
         if (c == 1) start = 1'b0;
         observe();
         if (done) seen_done++;
      end
      check("rm_pre_state", 32'(dbg.state), 32'(S_INJECT));
      #2 rst = 1'b1;
      #1;
      check("rm_dout",    32'(dout), 32'd0);
      check("rm_valid",   32'(dout_valid), 32'd0);
      check("rm_exp_det", 32'(exp_detect), 32'd0);
      check("rm_busy",    32'(busy), 32'd0);
      check("rm_done",    32'(done), 32'd0);
      check("rm_inj_cnt", 32'(inj_count), 32'd0);
      check("rm_state",   32'(dbg.state), 32'(S_IDLE));
      check("rm_lfsr",    32'(dbg.lfsr), 32'h0000ACE1);
      exp_q.delete();
      tick();
      rst = 1'b0;
      for (int c = 0; c < 5; c++) begin
         tick();
         if (done) seen_done++;
      end
      check("rm_no_done", 32'(seen_done), 32'd0);
      push_frame(8'd5, 8'd2);
      kick(8'd5, 8'd2);
      capture(60);
      check("rm_rerun_bits", 32'(f_bits), 32'h000217CB);
      check("rm_rerun_done", 32'(f_done), 32'd19);
      tick();

      // closed loop against the Moore detector
      for (int fr = 0; fr < 100; fr++) begin
         g = 8'($urandom_range(0, 6));
         n = 8'($urandom_range(0, 4));
         push_frame(g, n);
         kick(g, n);
         capture(100);
         check("cl_len",    32'(f_val), 32'(int'(n) * (int'(g) + 4)));
         check("cl_mism",   32'(f_mism), 32'd0);
         check("cl_inj",    32'(inj_count), 32'(n));
         check("cl_q_left", 32'(exp_q.size()), 32'd0);
         exp_q.delete();
         tick();
      end

      // final report
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
